// File: rtl/pipe_ctrl.sv
// Hazard / sequencing controller for the 5-stage RV32 pipeline with an EX/MEM/WB destination scoreboard.
// Define PIPE_CTRL_FORWARD_EN for load-use-only stalls plus registered EX forward selects.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        id_valid,
    input  logic        id_rs1_read,
    input  logic        id_rs2_read,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rd_write,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_mem_read,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_hold,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_hold,
    output logic        idex_bubble,
    output logic        exmem_hold,
    output logic        memwb_hold,
    output logic        ex_valid,
    output logic        mem_valid,
    output logic        wb_valid,
    output logic [1:0]  ex_fwd_rs1_sel,
    output logic [1:0]  ex_fwd_rs2_sel,
    output logic [31:0] stall_cnt
);
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              rd_write;
        logic [REG_AW-1:0] rd_addr;
        logic              mem_read;
    } sb_ent_t;

    // vld_pipe[0]=EX, [1]=MEM, [2]=WB
    logic [2:0] vld_pipe;
    sb_ent_t    ex_q, mem_q, wb_q, id_ent;

    function automatic logic src_match(input logic rd, input logic [REG_AW-1:0] a,
                                       input logic v, input sb_ent_t e);
        return rd & (a != '0) & v & e.rd_write & (e.rd_addr == a);
    endfunction

    logic m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
    logic haz, redir, haz_eff, bubble;

    always_comb begin
        m_ex1  = src_match(id_rs1_read, id_rs1_addr, vld_pipe[0], ex_q);
        m_ex2  = src_match(id_rs2_read, id_rs2_addr, vld_pipe[0], ex_q);
        m_mem1 = src_match(id_rs1_read, id_rs1_addr, vld_pipe[1], mem_q);
        m_mem2 = src_match(id_rs2_read, id_rs2_addr, vld_pipe[1], mem_q);
        m_wb1  = src_match(id_rs1_read, id_rs1_addr, vld_pipe[2], wb_q);
        m_wb2  = src_match(id_rs2_read, id_rs2_addr, vld_pipe[2], wb_q);
    end

`ifdef PIPE_CTRL_FORWARD_EN
    assign haz = id_valid & (m_ex1 | m_ex2) & ex_q.mem_read;
`else
    assign haz = id_valid & (m_ex1 | m_ex2 | m_mem1 | m_mem2 | m_wb1 | m_wb2);
`endif

    // mem_busy dominates, then redirect, then hazard
    assign redir   = ex_redirect & vld_pipe[0] & ~mem_busy;
    assign haz_eff = haz & ~mem_busy & ~redir;
    assign bubble  = redir | haz_eff;

    assign pc_hold     = mem_busy | haz_eff;
    assign ifid_hold   = mem_busy | haz_eff;
    assign ifid_flush  = redir;
    assign idex_hold   = mem_busy;
    assign idex_bubble = bubble;
    assign exmem_hold  = mem_busy;
    assign memwb_hold  = mem_busy;

    assign ex_valid  = vld_pipe[0];
    assign mem_valid = vld_pipe[1];
    assign wb_valid  = vld_pipe[2];

    assign id_ent = '{rd_write: id_rd_write, rd_addr: id_rd_addr, mem_read: id_mem_read};

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            vld_pipe  <= '0;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else if (!mem_busy) begin
            vld_pipe <= {vld_pipe[1:0], id_valid & ~bubble};
            wb_q     <= mem_q;
            mem_q    <= ex_q;
            ex_q     <= bubble ? '0 : id_ent;
            if (haz_eff)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

`ifdef PIPE_CTRL_FORWARD_EN
    // EX producer will sit in MEM when the consumer reaches EX, so it wins over MEM
    function automatic logic [1:0] fwd_sel(input logic mex, input logic mmem);
        return mex ? 2'd1 : (mmem ? 2'd2 : 2'd0);
    endfunction

    logic [1:0] fwd1_q, fwd2_q;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fwd1_q <= '0;
            fwd2_q <= '0;
        end else if (!mem_busy) begin
            fwd1_q <= bubble ? 2'd0 : fwd_sel(m_ex1, m_mem1);
            fwd2_q <= bubble ? 2'd0 : fwd_sel(m_ex2, m_mem2);
        end
    end
    assign ex_fwd_rs1_sel = fwd1_q;
    assign ex_fwd_rs2_sel = fwd2_q;

    logic sb_unused;
    assign sb_unused = ^{mem_q.mem_read, wb_q, m_wb1, m_wb2};
`else
    assign ex_fwd_rs1_sel = 2'd0;
    assign ex_fwd_rs2_sel = 2'd0;

    logic sb_unused;
    assign sb_unused = ^{ex_q.mem_read, mem_q.mem_read, wb_q.mem_read};
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; expectations adapt to PIPE_CTRL_FORWARD_EN.
module tb_pipe_ctrl;
`ifdef PIPE_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_b;
    logic        id_valid, id_rs1_read, id_rs2_read, id_rd_write, id_mem_read;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        ex_redirect, mem_busy;
    logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_hold;
    logic        ex_valid, mem_valid, wb_valid;
    logic [1:0]  ex_fwd_rs1_sel, ex_fwd_rs2_sel;
    logic [31:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n;
    logic [31:0] exp_cnt;

    pipe_ctrl dut (
        .clk(clk), .rst_b(rst_b),
        .id_valid(id_valid), .id_rs1_read(id_rs1_read), .id_rs2_read(id_rs2_read),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_write(id_rd_write), .id_rd_addr(id_rd_addr), .id_mem_read(id_mem_read),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_hold(idex_hold), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .memwb_hold(memwb_hold),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .ex_fwd_rs1_sel(ex_fwd_rs1_sel), .ex_fwd_rs2_sel(ex_fwd_rs2_sel),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [4:0] rd, input logic ld,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        id_valid    = 1'b1;
        id_rd_write = wr;  id_rd_addr  = rd;  id_mem_read = ld;
        id_rs1_read = r1;  id_rs1_addr = a1;
        id_rs2_read = r2;  id_rs2_addr = a2;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_rd_write = 1'b0; id_rd_addr = '0; id_mem_read = 1'b0;
        id_rs1_read = 1'b0; id_rs1_addr = '0; id_rs2_read = 1'b0; id_rs2_addr = '0;
    endtask

    // {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_hold}
    function automatic logic [31:0] ctl();
        return {25'd0, pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, memwb_hold};
    endfunction

    function automatic logic [31:0] vld();
        return {29'd0, wb_valid, mem_valid, ex_valid};
    endfunction

    initial begin
        idle();
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;
        rst_b       = 1'b0;
        #12;
        chk("rst_ctl", ctl(), 32'd0);
        chk("rst_vld", vld(), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        step();

        // ALU back-to-back: add x3,x1,x2 ; sub x4,x0,x3
        issue(1'b1, 5'd3, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2);
        #2 chk("alu_first_nostall", ctl(), 32'd0);
        step();
        issue(1'b1, 5'd4, 1'b0, 1'b1, 5'd0, 1'b1, 5'd3);
        #2 chk("alu_stall_ctl", ctl(), FWD ? 32'd0 : 32'b1100100);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!pc_hold) break;
            n++;
            step();
        end
        chk("alu_stall_cycles", n, FWD ? 32'd0 : 32'd3);
        step();
        idle();
        chk("alu_ex_valid", ex_valid, 1'b1);
        chk("alu_fwd_rs1", ex_fwd_rs1_sel, 2'd0);
        chk("alu_fwd_rs2", ex_fwd_rs2_sel, FWD ? 2'd1 : 2'd0);
        exp_cnt = FWD ? 32'd0 : 32'd3;
        chk("alu_cnt", stall_cnt, exp_cnt);

        // x0 write then x0 read never stalls
        issue(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        issue(1'b1, 5'd9, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
        #2 chk("x0_nostall", ctl(), 32'd0);
        step();
        idle();
        repeat (4) step();

        // Load-use: lw x5 ; add x6,x5,x1
        issue(1'b1, 5'd5, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
        step();
        issue(1'b1, 5'd6, 1'b0, 1'b1, 5'd5, 1'b1, 5'd1);
        #2 chk("lu_stall_ctl", ctl(), 32'b1100100);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!pc_hold) break;
            n++;
            step();
        end
        chk("lu_stall_cycles", n, FWD ? 32'd1 : 32'd3);
        step();
        idle();
        chk("lu_fwd_rs1", ex_fwd_rs1_sel, FWD ? 2'd2 : 2'd0);
        chk("lu_fwd_rs2", ex_fwd_rs2_sel, 2'd0);
        chk("lu_wb_valid", wb_valid, FWD);
        exp_cnt = exp_cnt + (FWD ? 32'd1 : 32'd3);
        chk("lu_cnt", stall_cnt, exp_cnt);
        repeat (4) step();

        // Redirect with a simultaneous load-use hazard
        issue(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        issue(1'b1, 5'd8, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
        ex_redirect = 1'b1;
        #2 chk("redir_ctl", ctl(), 32'b0010100);
        step();
        ex_redirect = 1'b0;
        idle();
        chk("redir_cnt", stall_cnt, exp_cnt);
        chk("redir_vld", vld(), 32'b010);
        repeat (4) step();

        // mem_busy with redirect pending
        issue(1'b1, 5'd9, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0);
        step();
        idle();
        mem_busy    = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2 chk("busy_ctl", ctl(), 32'b1101011);
            chk("busy_vld", vld(), 32'b001);
            step();
        end
        mem_busy = 1'b0;
        #2 chk("busy_release_ctl", ctl(), 32'b0010100);
        step();
        ex_redirect = 1'b0;
        chk("busy_release_vld", vld(), 32'b010);

        // Asynchronous reset mid-stream while a hazard-causing pair is live
        issue(1'b1, 5'd10, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        issue(1'b1, 5'd11, 1'b0, 1'b1, 5'd10, 1'b0, 5'd0);
        @(negedge clk);
        chk("pre_rst_stall", pc_hold, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        chk("mid_rst_vld", vld(), 32'd0);
        chk("mid_rst_cnt", stall_cnt, 32'd0);
        chk("mid_rst_ctl", ctl(), 32'd0);
        chk("mid_rst_fwd", {30'd0, ex_fwd_rs1_sel}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
